seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter; the driving end of the Moore sequence-detector interface.
- Captures a parallel pattern and emits it one bit per clock on `x`, MSB-first.
- Supports a programmable frame count and an inter-frame gap.
- Drives the detector's `x` input in system-level benches and in self-test logic.
- Moore FSM; every output is registered.

---
 rtl/seq_gen_pkg.sv | 16 +
 rtl/seq_gen_lfsr.sv | 33 +++
 rtl/seq_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - state encoding and LFSR constants shared by seq_pattern_gen and seq_gen_lfsr
package seq_gen_pkg;

  // Burst sequencer states; IDLE is the all-zero reset encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Gap-filler PRBS7 (x^7 + x^6 + 1): seed after reset and feedback tap mask
  localparam logic [6:0] LFSR_SEED = 7'h01;
  localparam logic [6:0] LFSR_TAPS = 7'h60;

endpackage

// File: rtl/seq_gen_lfsr.sv
// rtl/seq_gen_lfsr.sv - 7-bit Fibonacci LFSR with enable, used as gap filler
module seq_gen_lfsr
  import seq_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_out
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  // Shift left with the parity of the tapped bits entering at bit 0
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[5:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // State register, reseeded on reset so the filler sequence is repeatable
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[0];

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter; SEQ_GEN_PRBS_GAP_EN fills gaps with PRBS
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PAT_W-1:0]       pattern,
  input  logic [$clog2(PAT_W):0] pat_len,
  input  logic [CNT_W-1:0]       repeat_cnt,
  input  logic [GAP_W-1:0]       gap_len,
  output logic                   x,
  output logic                   x_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] top_q, top_d;       // index of the first (MSB) bit of a frame
  logic [IDX_W-1:0] idx_q, idx_d;       // index of the bit currently on x
  logic [CNT_W-1:0] frames_q, frames_d; // frames still to send after the current one
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_eff;
  logic [IDX_W-1:0] cap_top;
  logic             gap_fill;

  // Zero or oversize lengths fall back to the full pattern width
  always_comb begin
    len_eff = pat_len;
    if ((pat_len == '0) || (pat_len > LEN_W'(PAT_W))) begin
      len_eff = LEN_W'(PAT_W);
    end
  end

  assign cap_top = IDX_W'(len_eff - LEN_W'(1));

`ifdef SEQ_GEN_PRBS_GAP_EN
  logic lfsr_en;

  // The LFSR steps exactly once per gap cycle it supplies a bit for
  assign lfsr_en = (state_d == GAP);

  seq_gen_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (lfsr_en),
    .bit_out (gap_fill)
  );
`else
  assign gap_fill = 1'b0;
`endif

  // Next state and next registered outputs; outputs are computed for the cycle being entered
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    top_d     = top_q;
    idx_d     = idx_q;
    frames_d  = frames_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          pat_d     = pattern;
          top_d     = cap_top;
          idx_d     = cap_top;
          frames_d  = repeat_cnt;
          gap_d     = gap_len;
          x_d       = pattern[cap_top];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      SHIFT: begin
        if (idx_q != '0) begin
          idx_d     = idx_q - IDX_W'(1);
          x_d       = pat_q[idx_d];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (frames_q != '0) begin
          frames_d = frames_q - CNT_W'(1);
          busy_d   = 1'b1;
          if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q - GAP_W'(1);
            x_d       = gap_fill;
          end else begin
            idx_d     = top_q;
            x_d       = pat_q[top_q];
            x_valid_d = 1'b1;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          x_d       = gap_fill;
        end else begin
          state_d   = SHIFT;
          idx_d     = top_q;
          x_d       = pat_q[top_q];
          x_valid_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs registered; reset aborts any burst in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      top_q     <= '0;
      idx_q     <= '0;
      frames_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      top_q     <= top_d;
      idx_q     <= idx_d;
      frames_q  <= frames_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen; models SEQ_GEN_PRBS_GAP_EN filler when defined
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [2:0] pat_len;
  logic [3:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_W (4),
    .CNT_W (4),
    .GAP_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  // expected {x, x_valid, busy, done} for one cycle
  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         compared   = 0;
  int         mismatched = 0;
  logic [6:0] m_lfsr;
  logic [3:0] det_sr;
  int         det_hits;

  // scoreboard: one expected entry consumed per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      compared++;
      assert ({x, x_valid, busy, done} === cur.v)
      else begin
        mismatched++;
        $error("FAIL %s: observed x/xv/busy/done=%b expected %b", cur.tag, {x, x_valid, busy, done}, cur.v);
      end
    end
  end

  // downstream overlapping 1011 detector on valid bits
  always @(negedge clk) begin
    if (x_valid === 1'b1) begin
      det_sr = {det_sr[2:0], x};
      if (det_sr == 4'b1011) det_hits++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v, input string tag);
    exp_t t;
    t.v   = v;
    t.tag = tag;
    exp_q.push_back(t);
  endtask

  task automatic next_fill(output logic b);
`ifdef SEQ_GEN_PRBS_GAP_EN
    b      = m_lfsr[0];
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`else
    b = 1'b0;
`endif
  endtask

  task automatic push_burst(input logic [3:0] pat, input int len, input int rep, input int gap,
                            input string tag);
    int   le;
    logic b;
    le = (len == 0 || len > 4) ? 4 : len;
    for (int f = 0; f <= rep; f++) begin
      for (int i = le - 1; i >= 0; i--) begin
        push({pat[i], 1'b1, 1'b1, 1'b0}, $sformatf("%s_f%0d_b%0d", tag, f, i));
      end
      if (f < rep) begin
        for (int g = 0; g < gap; g++) begin
          next_fill(b);
          push({b, 1'b0, 1'b1, 1'b0}, $sformatf("%s_gap%0d_%0d", tag, f, g));
        end
      end
    end
    push(4'b0001, {tag, "_done"});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      step();
      n++;
    end
    compared++;
    assert (exp_q.size() == 0)
    else begin
      mismatched++;
      $error("FAIL %s_timeout: observed %0d pending entries expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [3:0] pat, input logic [2:0] len, input int rep, input int gap,
                     input string tag);
    pattern    = pat;
    pat_len    = len;
    repeat_cnt = 4'(rep);
    gap_len    = 4'(gap);
    push(4'b0000, {tag, "_idle"});
    push_burst(pat, int'(len), rep, gap, tag);
    push(4'b0000, {tag, "_post"});
    start = 1'b1;
    step();
    start      = 1'b0;
    pattern    = 4'($urandom);
    pat_len    = 3'($urandom);
    repeat_cnt = 4'($urandom);
    gap_len    = 4'($urandom);
    wait_drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    pattern    = '0;
    pat_len    = '0;
    repeat_cnt = '0;
    gap_len    = '0;
    m_lfsr     = 7'h01;
    det_sr     = '0;
    det_hits   = 0;

    // reset state
    step();
    push(4'b0000, "reset0");
    push(4'b0000, "reset1");
    step();
    step();
    rst = 1'b0;
    push(4'b0000, "reset_release");
    step();

    // single frame 1011
    run(4'b1011, 3'd4, 0, 0, "single");

    // three frames, no gap, contiguous; detector sees 3 hits
    det_sr   = '0;
    det_hits = 0;
    run(4'b1011, 3'd4, 2, 0, "rep3");
    compared++;
    assert (det_hits === 3)
    else begin
      mismatched++;
      $error("FAIL det_hits: observed %0d expected 3", det_hits);
    end

    // two frames with a 2-cycle gap
    run(4'b1011, 3'd4, 1, 2, "gap2");

    // length handling: short, zero (clamped), oversize (clamped)
    run(4'b0101, 3'd3, 0, 0, "len3");
    run(4'b0101, 3'd0, 0, 0, "len0");
    run(4'b0101, 3'd7, 0, 0, "len7");

    // start while busy with a different pattern is ignored
    pattern    = 4'b1011;
    pat_len    = 3'd4;
    repeat_cnt = 4'd0;
    gap_len    = 4'd0;
    push(4'b0000, "busy_idle");
    push_burst(4'b1011, 4, 0, 0, "busy");
    push(4'b0000, "busy_post");
    start = 1'b1;
    step();
    start      = 1'b0;
    pattern    = 4'b0100;
    pat_len    = 3'd3;
    repeat_cnt = 4'd5;
    gap_len    = 4'd3;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_drain("busy");

    // start held high: ignored in DONE, accepted one idle cycle later
    pattern    = 4'b0101;
    pat_len    = 3'd3;
    repeat_cnt = 4'd0;
    gap_len    = 4'd0;
    push(4'b0000, "b2b_idle");
    push_burst(4'b0101, 3, 0, 0, "b2b1");
    push(4'b0000, "b2b_between");
    push_burst(4'b0101, 3, 0, 0, "b2b2");
    push(4'b0000, "b2b_post");
    start = 1'b1;
    repeat (6) step();
    start = 1'b0;
    wait_drain("b2b");

    // reset mid-frame aborts the burst
    pattern    = 4'b1011;
    pat_len    = 3'd4;
    repeat_cnt = 4'd3;
    gap_len    = 4'd2;
    push(4'b0000, "rst_idle");
    push(4'b1110, "rst_b3");
    push(4'b0110, "rst_b2");
    push(4'b0000, "rst_abort");
    push(4'b0000, "rst_hold");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    m_lfsr = 7'h01;
    wait_drain("rst");

    // fresh burst after reset starts at the MSB; long gap exposes filler
    run(4'b1011, 3'd4, 1, 7, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
